// File: rtl/sdram_port_arb.sv
// sdram_port_arb: shares the single sdram_controller command port between the
// TFT refill reader (high priority) and the UART page writer (low priority,
// anti-starvation), issuing one-cycle enables and returning acks and read data.
// Latency: request sampled in cycle N, enable in N+1, ack one cycle after the
// owner's completion strobe; 4-cycle minimum command spacing.
// Backpressure: req/ack handshake; ctrl_busy or arb_en=0 hold requests pending.
// Ports: clk/rst (async active-low); rd_* read port; wr_* write port;
// ctrl_* controller side; arb_owner = owner of last grant; arb_err = sticky
// watchdog flag.
// Optional feature: define ARB_TIMEOUT_EN to build the WAIT watchdog.
module sdram_port_arb #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 16,
  parameter int RD_BURST_MAX = 8,
  parameter int TIMEOUT_CYC  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_en,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ctrl_rd_enable,
  output logic              ctrl_wr_enable,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wr_data,
  input  logic [DATA_W-1:0] ctrl_rd_data,
  input  logic              ctrl_rd_ready,
  input  logic              ctrl_wr_done,
  input  logic              ctrl_busy,
  output logic              arb_owner,
  output logic              arb_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] BURST = 4'(RD_BURST_MAX);

  logic [1:0] state;
  logic [3:0] streak;
  logic       start;
  logic       grant_wr;
  logic       owner_done;
  logic       wdog_hit;

  assign start      = (state == S_IDLE) && arb_en && !ctrl_busy && (rd_req || wr_req);
  // Reads win ties until they have taken BURST grants in a row over a waiting write.
  assign grant_wr   = wr_req && (!rd_req || (streak == BURST));
  // Only the current owner's strobe may end WAIT; the other one is ignored.
  assign owner_done = arb_owner ? ctrl_wr_done : ctrl_rd_ready;

`ifdef ARB_TIMEOUT_EN
  localparam logic [9:0] WDOG_LIMIT = 10'(TIMEOUT_CYC);
  logic [9:0] wdog;

  // Compare the incremented value so the exit happens on the WAIT cycle in
  // which the counter reaches the limit, giving an ack TIMEOUT_CYC+1 after ISSUE.
  assign wdog_hit = (state == S_WAIT) && ((wdog + 10'd1) == WDOG_LIMIT) && !owner_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog    <= '0;
      arb_err <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 10'd1;
      if (wdog_hit)             arb_err <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign arb_err  = 1'b0;
`endif

  // Read streak against a waiting write; any cycle without wr_req forgets it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (!wr_req) begin
      streak <= '0;
    end else if (start) begin
      if (grant_wr)             streak <= '0;
      else if (streak != BURST) streak <= streak + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      rd_ack         <= 1'b0;
      wr_ack         <= 1'b0;
      ctrl_rd_enable <= 1'b0;
      ctrl_wr_enable <= 1'b0;
      rd_data        <= '0;
      ctrl_addr      <= '0;
      ctrl_wr_data   <= '0;
      arb_owner      <= 1'b0;
    end else begin
      rd_ack         <= 1'b0;
      wr_ack         <= 1'b0;
      ctrl_rd_enable <= 1'b0;
      ctrl_wr_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_ISSUE;
            arb_owner      <= grant_wr;
            ctrl_addr      <= grant_wr ? wr_addr : rd_addr;
            ctrl_rd_enable <= !grant_wr;
            ctrl_wr_enable <= grant_wr;
            if (grant_wr) ctrl_wr_data <= wr_data;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (owner_done) begin
            state <= S_DONE;
            if (arb_owner) begin
              wr_ack <= 1'b1;
            end else begin
              rd_ack  <= 1'b1;
              rd_data <= ctrl_rd_data;
            end
          end else if (wdog_hit) begin
            // Abandoned transfer still acks its owner so the requester moves on.
            state  <= S_DONE;
            wr_ack <= arb_owner;
            rd_ack <= !arb_owner;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
module tb_sdram_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_en;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        ctrl_rd_enable;
  logic        ctrl_wr_enable;
  logic [21:0] ctrl_addr;
  logic [15:0] ctrl_wr_data;
  logic [15:0] ctrl_rd_data;
  logic        ctrl_rd_ready;
  logic        ctrl_wr_done;
  logic        ctrl_busy;
  logic        arb_owner;
  logic        arb_err;

  int errors = 0;
  int checks = 0;

  sdram_port_arb #(
    .ADDR_W(22), .DATA_W(16), .RD_BURST_MAX(8), .TIMEOUT_CYC(15)
  ) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ctrl_rd_enable(ctrl_rd_enable), .ctrl_wr_enable(ctrl_wr_enable),
    .ctrl_addr(ctrl_addr), .ctrl_wr_data(ctrl_wr_data),
    .ctrl_rd_data(ctrl_rd_data), .ctrl_rd_ready(ctrl_rd_ready),
    .ctrl_wr_done(ctrl_wr_done), .ctrl_busy(ctrl_busy),
    .arb_owner(arb_owner), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic test_reset();
    rst = 1'b0; arb_en = 1'b1; rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0;
    wr_data = '0; ctrl_rd_data = '0; ctrl_rd_ready = 0; ctrl_wr_done = 0; ctrl_busy = 0;
    repeat (2) @(negedge clk);
    checks++; if ({rd_ack, wr_ack, ctrl_rd_enable, ctrl_wr_enable} !== 4'b0) begin errors++;
      $display("FAIL reset_pulses: got %b want 0000", {rd_ack, wr_ack, ctrl_rd_enable, ctrl_wr_enable}); end
    checks++; if ({rd_data, ctrl_addr, ctrl_wr_data} !== 54'h0) begin errors++;
      $display("FAIL reset_data: rd_data=%h ctrl_addr=%h ctrl_wr_data=%h want 0", rd_data, ctrl_addr, ctrl_wr_data); end
    checks++; if ({arb_owner, arb_err} !== 2'b00) begin errors++;
      $display("FAIL reset_flags: owner=%b err=%b want 0 0", arb_owner, arb_err); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({ctrl_rd_enable, ctrl_wr_enable} !== 2'b00) begin errors++;
      $display("FAIL idle_no_grant: enables=%b want 00", {ctrl_rd_enable, ctrl_wr_enable}); end
  endtask

  task automatic test_single_read();
    int wr_acks = 0;
    rd_addr = 22'h0A0123; rd_req = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_rd_enable !== 1'b1 || ctrl_wr_enable !== 1'b0 || ctrl_addr !== 22'h0A0123) begin errors++;
      $display("FAIL single_issue: rd_en=%b wr_en=%b addr=%h want 1 0 0a0123", ctrl_rd_enable, ctrl_wr_enable, ctrl_addr); end
    repeat (2) begin
      @(negedge clk);
      checks++; if ({ctrl_rd_enable, rd_ack} !== 2'b00) begin errors++;
        $display("FAIL single_wait: rd_en=%b rd_ack=%b want 0 0", ctrl_rd_enable, rd_ack); end
    end
    @(negedge clk);
    ctrl_rd_ready = 1'b1; ctrl_rd_data = 16'hF800;
    @(negedge clk);
    ctrl_rd_ready = 1'b0; ctrl_rd_data = 16'h0000;
    if (wr_ack) wr_acks++;
    checks++; if (rd_ack !== 1'b1 || rd_data !== 16'hF800 || arb_owner !== 1'b0) begin errors++;
      $display("FAIL single_ack: rd_ack=%b rd_data=%h owner=%b want 1 f800 0", rd_ack, rd_data, arb_owner); end
    rd_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wr_ack) wr_acks++;
    end
    checks++; if (rd_ack !== 1'b0 || rd_data !== 16'hF800 || wr_acks != 0 || ctrl_rd_enable !== 1'b0) begin errors++;
      $display("FAIL single_after: rd_ack=%b rd_data=%h wr_acks=%0d rd_en=%b want 0 f800 0 0", rd_ack, rd_data, wr_acks, ctrl_rd_enable); end
  endtask

  task automatic test_simultaneous();
    int grants = 0, acks_r = 0, acks_w = 0, last_e = -1, cyc = 0;
    logic pend_r = 1'b0, pend_w = 1'b0, exp_w;
    rd_addr = 22'h000010; wr_addr = 22'h3F0001; wr_data = 16'h07E0;
    rd_req = 1'b1; wr_req = 1'b1;
    while ((acks_r + acks_w) < 18 && cyc < 300) begin
      @(negedge clk); cyc++;
      ctrl_rd_ready = 1'b0; ctrl_wr_done = 1'b0;
      if (rd_ack) acks_r++;
      if (wr_ack) acks_w++;
      if ((acks_r + acks_w) == 18) begin rd_req = 1'b0; wr_req = 1'b0; end
      if (pend_r) begin ctrl_rd_ready = 1'b1; ctrl_rd_data = 16'hC000 | 16'(grants - 1); pend_r = 1'b0; end
      if (pend_w) begin ctrl_wr_done = 1'b1; pend_w = 1'b0; end
      if (ctrl_rd_enable || ctrl_wr_enable) begin
        exp_w = ((grants % 9) == 8);
        checks++; if (ctrl_wr_enable !== exp_w || ctrl_rd_enable !== !exp_w
                      || ctrl_addr !== (exp_w ? 22'h3F0001 : 22'h000010)) begin errors++;
          $display("FAIL grant_%0d: wr_en=%b rd_en=%b addr=%h want wr_en=%b", grants, ctrl_wr_enable, ctrl_rd_enable, ctrl_addr, exp_w); end
        if (exp_w) begin
          checks++; if (ctrl_wr_data !== 16'h07E0 || arb_owner !== 1'b1) begin errors++;
            $display("FAIL grant_wdata_%0d: data=%h owner=%b want 07e0 1", grants, ctrl_wr_data, arb_owner); end
        end
        if (last_e >= 0) begin
          checks++; if (cyc - last_e != 4) begin errors++;
            $display("FAIL spacing_%0d: got %0d want 4", grants, cyc - last_e); end
        end
        last_e = cyc; pend_r = ctrl_rd_enable; pend_w = ctrl_wr_enable; grants++;
      end
    end
    ctrl_rd_ready = 1'b0; ctrl_wr_done = 1'b0;
    checks++; if (grants != 18 || acks_r != 16 || acks_w != 2) begin errors++;
      $display("FAIL simul_totals: grants=%0d rd_acks=%0d wr_acks=%0d want 18 16 2", grants, acks_r, acks_w); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy();
    int en_cnt = 0;
    ctrl_busy = 1'b1; wr_addr = 22'h1ABCDE; wr_data = 16'h001F; wr_req = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ctrl_rd_enable || ctrl_wr_enable) en_cnt++;
    end
    checks++; if (en_cnt != 0) begin errors++;
      $display("FAIL busy_hold: enables=%0d want 0", en_cnt); end
    ctrl_busy = 1'b0;
    @(negedge clk);
    checks++; if (ctrl_wr_enable !== 1'b1 || ctrl_addr !== 22'h1ABCDE || ctrl_wr_data !== 16'h001F || arb_owner !== 1'b1) begin errors++;
      $display("FAIL busy_release: wr_en=%b addr=%h data=%h owner=%b want 1 1abcde 001f 1", ctrl_wr_enable, ctrl_addr, ctrl_wr_data, arb_owner); end
    @(negedge clk); ctrl_wr_done = 1'b1;
    @(negedge clk); ctrl_wr_done = 1'b0;
    checks++; if (wr_ack !== 1'b1) begin errors++;
      $display("FAIL busy_ack: wr_ack=%b want 1", wr_ack); end
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_foreign_strobe();
    wr_addr = 22'h2000FF; wr_data = 16'hABCD; wr_req = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_wr_enable !== 1'b1) begin errors++;
      $display("FAIL foreign_issue: wr_en=%b want 1", ctrl_wr_enable); end
    @(negedge clk); ctrl_rd_ready = 1'b1; ctrl_rd_data = 16'h1234;
    @(negedge clk); ctrl_rd_ready = 1'b0; ctrl_rd_data = 16'h0000;
    @(negedge clk);
    checks++; if ({rd_ack, wr_ack} !== 2'b00 || rd_data !== 16'hC010) begin errors++;
      $display("FAIL foreign_ignored: rd_ack=%b wr_ack=%b rd_data=%h want 0 0 c010", rd_ack, wr_ack, rd_data); end
    ctrl_wr_done = 1'b1;
    @(negedge clk); ctrl_wr_done = 1'b0;
    checks++; if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin errors++;
      $display("FAIL foreign_ack: wr_ack=%b rd_ack=%b want 1 0", wr_ack, rd_ack); end
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arb_en();
    int en_cnt = 0;
    arb_en = 1'b0; rd_addr = 22'h000777; rd_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ctrl_rd_enable || ctrl_wr_enable) en_cnt++;
    end
    checks++; if (en_cnt != 0) begin errors++;
      $display("FAIL arb_en_off: enables=%0d want 0", en_cnt); end
    arb_en = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_rd_enable !== 1'b1 || ctrl_addr !== 22'h000777) begin errors++;
      $display("FAIL arb_en_on: rd_en=%b addr=%h want 1 000777", ctrl_rd_enable, ctrl_addr); end
    arb_en = 1'b0;
    @(negedge clk); ctrl_rd_ready = 1'b1; ctrl_rd_data = 16'h0F0F;
    @(negedge clk); ctrl_rd_ready = 1'b0;
    checks++; if (rd_ack !== 1'b1 || rd_data !== 16'h0F0F) begin errors++;
      $display("FAIL arb_en_complete: rd_ack=%b rd_data=%h want 1 0f0f", rd_ack, rd_data); end
    en_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ctrl_rd_enable || ctrl_wr_enable) en_cnt++;
    end
    checks++; if (en_cnt != 0) begin errors++;
      $display("FAIL arb_en_parked: enables=%0d want 0", en_cnt); end
    rd_req = 1'b0; arb_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ack_cnt = 0;
    rd_addr = 22'h155555; rd_req = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_rd_enable !== 1'b1) begin errors++;
      $display("FAIL rstmid_issue: rd_en=%b want 1", ctrl_rd_enable); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if ({rd_ack, wr_ack, ctrl_rd_enable, ctrl_wr_enable, arb_owner, arb_err, rd_data, ctrl_addr, ctrl_wr_data} !== 60'h0) begin errors++;
      $display("FAIL rstmid_clear: ack=%b%b en=%b%b own=%b err=%b rd_data=%h addr=%h wdata=%h want all 0",
               rd_ack, wr_ack, ctrl_rd_enable, ctrl_wr_enable, arb_owner, arb_err, rd_data, ctrl_addr, ctrl_wr_data); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_rd_enable !== 1'b1 || ctrl_addr !== 22'h155555) begin errors++;
      $display("FAIL rstmid_reissue: rd_en=%b addr=%h want 1 155555", ctrl_rd_enable, ctrl_addr); end
    @(negedge clk); ctrl_rd_ready = 1'b1; ctrl_rd_data = 16'h5A5A;
    repeat (4) begin
      @(negedge clk); ctrl_rd_ready = 1'b0;
      if (rd_ack) begin ack_cnt++; rd_req = 1'b0; end
    end
    checks++; if (ack_cnt != 1 || rd_data !== 16'h5A5A) begin errors++;
      $display("FAIL rstmid_acks: acks=%0d rd_data=%h want 1 5a5a", ack_cnt, rd_data); end
    rd_req = 1'b0;
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int ack_at = -1;
    rd_addr = 22'h0000AA; rd_req = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_rd_enable !== 1'b1) begin errors++;
      $display("FAIL timeout_issue: rd_en=%b want 1", ctrl_rd_enable); end
    for (int k = 1; k <= 20 && ack_at < 0; k++) begin
      @(negedge clk);
      if (rd_ack) begin ack_at = k; rd_req = 1'b0; end
    end
    checks++; if (ack_at != 16 || arb_err !== 1'b1 || rd_data !== 16'h5A5A) begin errors++;
      $display("FAIL timeout_ack: ack_after=%0d err=%b rd_data=%h want 16 1 5a5a", ack_at, arb_err, rd_data); end
    rd_req = 1'b0;
    @(negedge clk);
    wr_addr = 22'h300003; wr_data = 16'h1111; wr_req = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_wr_enable !== 1'b1 || ctrl_addr !== 22'h300003) begin errors++;
      $display("FAIL timeout_next_issue: wr_en=%b addr=%h want 1 300003", ctrl_wr_enable, ctrl_addr); end
    @(negedge clk); ctrl_wr_done = 1'b1;
    @(negedge clk); ctrl_wr_done = 1'b0;
    checks++; if (wr_ack !== 1'b1 || arb_err !== 1'b1) begin errors++;
      $display("FAIL timeout_next_ack: wr_ack=%b err=%b want 1 1", wr_ack, arb_err); end
    wr_req = 1'b0;
    @(negedge clk);
  endtask
`else
  task automatic test_timeout();
    int ack_cnt = 0;
    rd_addr = 22'h0000AA; rd_req = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_rd_enable !== 1'b1) begin errors++;
      $display("FAIL nowdog_issue: rd_en=%b want 1", ctrl_rd_enable); end
    repeat (40) begin
      @(negedge clk);
      if (rd_ack) ack_cnt++;
    end
    checks++; if (ack_cnt != 0 || arb_err !== 1'b0) begin errors++;
      $display("FAIL nowdog_wait: acks=%0d err=%b want 0 0", ack_cnt, arb_err); end
    ctrl_rd_ready = 1'b1; ctrl_rd_data = 16'h3C3C;
    @(negedge clk); ctrl_rd_ready = 1'b0;
    checks++; if (rd_ack !== 1'b1 || rd_data !== 16'h3C3C) begin errors++;
      $display("FAIL nowdog_ack: rd_ack=%b rd_data=%h want 1 3c3c", rd_ack, rd_data); end
    rd_req = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_busy();
    test_foreign_strobe();
    test_arb_en();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
